gf_clmul_seq: RTL and testbench
===============================

# gf_clmul_seq

Sequential carry-less (GF(2)[x]) multiplier producing the unreduced 2·DATA_WIDTH-bit product of two polynomial operands. It is the producer side of the sequential reduction stage: its product and op_finish feed the reducer's reduc_in / op_enable, and together they form a GF(2^m) multiplier. It uses the same level-held op_enable / op_finish handshake and runtime polyn_grade as the reducer. It consumes one multiplier bit per cycle, or two with the configuration option below.

## Interface
- DATA_WIDTH, 8, maximum operand width in bits (m_max).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- op_enable  input  1  level-held request; high starts an operation and must stay high until op_finish is observed.
- polyn_grade  input  $clog2(DATA_WIDTH)+1  active operand width g (field degree m); sampled at the load edge.
- a_in  input  DATA_WIDTH  multiplicand polynomial, bit i = coefficient of x^i.
- b_in  input  DATA_WIDTH  multiplier polynomial.
- out  output  2*DATA_WIDTH  unreduced product a·b over GF(2); valid only while op_finish=1, else 0.
- op_finish  output  1  registered; high while the result is held.

## Operation
- States: IDLE, RUN, DONE. Reset (rst_n=0, asynchronous) forces IDLE, out=0, op_finish=0, counter=0, accumulator=0.
- IDLE: at the first rising edge with op_enable=1 (load edge):
  - latch a = a_in, b = b_in, both masked to the low g bits;
  - effective g = min(polyn_grade, DATA_WIDTH);
  - clear the accumulator; set bit counter = g;
  - go to RUN, or to DONE directly if g = 0 (product 0).
- RUN: each edge processes b bit i = g−counter (LSB first):
  - if b[i]=1, acc ^= a << i; then counter−1;
  - on the edge that processes the last bit, go to DONE.
- DONE: op_finish=1, out=acc (degree ≤ 2g−2; upper bits 0).
  - Stays in DONE while op_enable=1.
  - op_enable=0 → IDLE next edge; out and op_finish return to 0.
- Abort: op_enable=0 in RUN → IDLE next edge; accumulator discarded, outputs stay 0.
- Operand or polyn_grade changes after the load edge are ignored until the next load.
- Back-to-back operations require op_enable low for at least one edge between them.
- Arithmetic: XOR only, no carries. Shift a<<i is computed in 2·DATA_WIDTH bits and never truncates.

## Timing
- Latency: op_finish rises after the edge that is g+1 edges from the load edge, counting the load edge (g=0 → 1 edge; g=8 → 9 edges).
- op_finish and out change only on clk edges or on asynchronous reset; no combinational path from inputs to outputs.
- op_finish falls one edge after op_enable is sampled low in DONE.
- Reset mid-RUN or mid-DONE: outputs go to 0 immediately; the next op_enable=1 edge starts a fresh load.

## Configuration
- GF_CLMUL_TWO_BIT_EN defined:
  - RUN processes bits i and i+1 per edge (acc ^= b[i]·(a<<i) ^ b[i+1]·(a<<(i+1))), counter decrements by 2 and saturates at 0;
  - RUN takes ceil(g/2) edges, latency ceil(g/2)+1 (g=8 → 5, g=3 → 3);
  - results are identical to the one-bit build.
- Undefined: one bit per edge, latency g+1.

## Test plan
- Reset: rst_n=0 with op_enable=1 and nonzero operands → out=0, op_finish=0; after release, operation starts at the next edge.
- Basic: g=4, a=0x0B, b=0x0D → out=0x007F, op_finish high 5 edges after load (3 edges with GF_CLMUL_TWO_BIT_EN).
- Full width: g=8, a=0xFF, b=0xFF → out=0x5555 after 9 edges (5 two-bit); g=4, a=0x0F, b=0x06 → 0x0022.
- Masking and clamping:
  - g=3, a=0xFF, b=0xFF → out=0x0015;
  - g=15 is clamped to 8 → 0x5555;
  - g=0 → out=0 with op_finish after 1 edge.
- Handshake:
  - hold op_enable high 20 cycles after finish → out stable, no restart;
  - drop op_enable → op_finish=0 next edge;
  - change a_in mid-RUN → result unaffected.
- Abort and reset: op_enable low mid-RUN → IDLE, op_finish never rises; rst_n pulse mid-RUN → outputs 0 asynchronously, and a new op (a=0x0B, b=0x0D, g=4) then gives 0x007F.

Source files
------------

// File: rtl/gf_clmul_if.sv
// Request/response bundle of the sequential carry-less multiplier.
// The level-held op_enable / op_finish handshake is shared with the reducer stage.
interface gf_clmul_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int GW = $clog2(DATA_WIDTH) + 1;

  logic                    op_enable;
  logic [GW-1:0]           polyn_grade;
  logic [DATA_WIDTH-1:0]   a_in;
  logic [DATA_WIDTH-1:0]   b_in;
  logic [2*DATA_WIDTH-1:0] out;
  logic                    op_finish;

  modport master (
    output op_enable, polyn_grade, a_in, b_in,
    input  out, op_finish
  );

  modport slave (
    input  op_enable, polyn_grade, a_in, b_in,
    output out, op_finish
  );
endinterface

// File: rtl/gf_clmul_seq.sv
// Sequential GF(2)[x] multiplier: unreduced 2*DATA_WIDTH-bit product, LSB-first over b.
// Define GF_CLMUL_TWO_BIT_EN to retire two multiplier bits per clock.
module gf_clmul_seq #(
  parameter int DATA_WIDTH = 8
) (
  input logic       clk,
  input logic       rst_n,
  gf_clmul_if.slave bus
);
  localparam int GW = $clog2(DATA_WIDTH) + 1;
  localparam int PW = 2 * DATA_WIDTH;
`ifdef GF_CLMUL_TWO_BIT_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam logic [GW-1:0] W_G    = GW'(DATA_WIDTH);
  localparam logic [GW-1:0] STEP_G = GW'(STEP);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         a_sh, acc;
  logic [DATA_WIDTH-1:0] b_sh;
  logic [GW-1:0]         cnt;
  logic [GW-1:0]         g_eff;
  logic [DATA_WIDTH-1:0] mask;
  logic [STEP:0][PW-1:0] pp;

  assign g_eff = (bus.polyn_grade > W_G) ? W_G : bus.polyn_grade;

  for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_mask
    assign mask[k] = (GW'(k) < g_eff);
  end

  // a is pre-shifted and b consumed from the bottom, so the active bits are always at index 0..STEP-1
  assign pp[0] = acc;
  for (genvar k = 0; k < STEP; k++) begin : g_step
    assign pp[k+1] = pp[k] ^ (b_sh[k] ? (a_sh << k) : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.op_enable) state_nxt = (g_eff == '0) ? DONE : RUN;
      RUN: begin
        if (!bus.op_enable)       state_nxt = IDLE;
        else if (cnt <= STEP_G)   state_nxt = DONE;
      end
      DONE: if (!bus.op_enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      cnt  <= '0;
      acc  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.op_enable) begin
          a_sh <= PW'(bus.a_in & mask);
          b_sh <= bus.b_in & mask;
          cnt  <= g_eff;
          acc  <= '0;
        end
        RUN: if (bus.op_enable) begin
          acc  <= pp[STEP];
          a_sh <= a_sh << STEP;
          b_sh <= b_sh >> STEP;
          cnt  <= (cnt > STEP_G) ? cnt - STEP_G : '0;
        end
        default: ;
      endcase
    end
  end

  // acc is frozen outside RUN, so outputs decode purely from registers
  always_comb begin
    bus.out       = '0;
    bus.op_finish = 1'b0;
    if (state == DONE) begin
      bus.out       = acc;
      bus.op_finish = 1'b1;
    end
  end
endmodule

// File: tb/tb_gf_clmul_seq.sv
// Scoreboard bench for gf_clmul_seq: driver pushes expected product/latency, monitor checks on op_finish rise.
module tb_gf_clmul_seq;
  localparam int DW = 8;
  localparam int GW = $clog2(DW) + 1;
`ifdef GF_CLMUL_TWO_BIT_EN
  localparam bit TWO = 1'b1;
`else
  localparam bit TWO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  gf_clmul_if #(.DATA_WIDTH(DW)) bus();
  gf_clmul_seq #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [2*DW-1:0] out;
    int              lat;
    string           name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   load_cyc = 0;
  logic fin_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  function automatic int lat_of(input int g);
    int ge;
    ge = (g > DW) ? DW : g;
    return TWO ? (ge + 1) / 2 + 1 : ge + 1;
  endfunction

  // Monitor: every op_finish rise must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.op_finish && !fin_d) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_finish", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk({e.name, "_out"}, 32'(bus.out), 32'(e.out));
        chk({e.name, "_latency"}, 32'(cyc - load_cyc + 1), 32'(e.lat));
      end
    end
    fin_d = bus.op_finish;
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input int g);
    bus.a_in        = a;
    bus.b_in        = b;
    bus.polyn_grade = GW'(g);
    bus.op_enable   = 1'b1;
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input int g,
                          input logic [15:0] e, input string nm);
    drive(a, b, g);
    sb_q.push_back('{out: e, lat: lat_of(g), name: nm});
    load_cyc = cyc + 1;
  endtask

  task automatic wait_finish(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (bus.op_finish) ok = 1'b1;
    end
    if (!ok) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_back());
    end
  endtask

  task automatic hold_and_drop(input logic [15:0] e, input int hold, input string nm);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({nm, "_hold_out"}, 32'(bus.out), 32'(e));
      chk({nm, "_hold_fin"}, 32'(bus.op_finish), 32'd1);
    end
    bus.op_enable = 1'b0;
    @(negedge clk);
    chk({nm, "_drop_fin"}, 32'(bus.op_finish), 32'd0);
    chk({nm, "_drop_out"}, 32'(bus.out), 32'd0);
  endtask

  initial begin
    bit saw;
    // reset asserted while a request is already pending
    drive(8'hFF, 8'hFF, 8);
    repeat (3) @(negedge clk);
    chk("reset_out", 32'(bus.out), 32'd0);
    chk("reset_fin", 32'(bus.op_finish), 32'd0);
    rst_n = 1'b1;
    start_op(8'hFF, 8'hFF, 8, 16'h5555, "post_reset");
    wait_finish("post_reset");
    hold_and_drop(16'h5555, 1, "post_reset");

    start_op(8'h0B, 8'h0D, 4, 16'h007F, "basic");
    wait_finish("basic");
    hold_and_drop(16'h007F, 20, "basic");

    start_op(8'hFF, 8'hFF, 8, 16'h5555, "full");
    wait_finish("full");
    hold_and_drop(16'h5555, 1, "full");

    start_op(8'h0F, 8'h06, 4, 16'h0022, "g4_0f_06");
    wait_finish("g4_0f_06");
    hold_and_drop(16'h0022, 1, "g4_0f_06");

    start_op(8'hFF, 8'hFF, 3, 16'h0015, "mask_g3");
    wait_finish("mask_g3");
    hold_and_drop(16'h0015, 1, "mask_g3");

    start_op(8'hFF, 8'hFF, 15, 16'h5555, "clamp_g15");
    wait_finish("clamp_g15");
    hold_and_drop(16'h5555, 1, "clamp_g15");

    start_op(8'hAB, 8'hCD, 0, 16'h0000, "g0");
    wait_finish("g0");
    hold_and_drop(16'h0000, 1, "g0");

    // operand and grade changes after the load edge must be ignored
    start_op(8'h0B, 8'h0D, 4, 16'h007F, "midrun_change");
    @(negedge clk);
    bus.a_in = 8'hFF;
    bus.b_in = 8'h00;
    bus.polyn_grade = GW'(8);
    wait_finish("midrun_change");
    hold_and_drop(16'h007F, 1, "midrun_change");

    // abort: op_enable dropped mid-RUN, no result may appear
    drive(8'hFF, 8'hFF, 8);
    repeat (3) @(negedge clk);
    bus.op_enable = 1'b0;
    saw = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.op_finish) saw = 1'b1;
    end
    chk("abort_no_finish", 32'(saw), 32'd0);

    // asynchronous reset while the result is held
    start_op(8'h0F, 8'h06, 4, 16'h0022, "done_reset");
    wait_finish("done_reset");
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out", 32'(bus.out), 32'd0);
    chk("async_reset_fin", 32'(bus.op_finish), 32'd0);
    bus.op_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset pulse mid-RUN, then a fresh operation
    drive(8'hFF, 8'hFF, 8);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("runreset_out", 32'(bus.out), 32'd0);
    chk("runreset_fin", 32'(bus.op_finish), 32'd0);
    bus.op_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(8'h0B, 8'h0D, 4, 16'h007F, "after_reset");
    wait_finish("after_reset");
    hold_and_drop(16'h007F, 1, "after_reset");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
